// File: rtl/conv_frame_streamer.sv
// Streams one frame from a synchronous-read frame memory as a raster-ordered
// valid/ready pixel stream with sof/eol/eof markers.
module conv_frame_streamer #(
    parameter  int WORD_SIZE = 8,
    parameter  int ROW_SIZE  = 540,
    parameter  int NUM_ROWS  = 480,
    localparam int ADDR_W    = $clog2(ROW_SIZE * NUM_ROWS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    output logic                 busy,
    output logic                 done,
    output logic                 mem_rd_en,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [WORD_SIZE-1:0] mem_rd_data,
    output logic [WORD_SIZE-1:0] pixel_out,
    output logic                 pixel_valid,
    input  logic                 pixel_ready,
    output logic                 sof,
    output logic                 eol,
    output logic                 eof
);

    localparam int NUM_PIX = ROW_SIZE * NUM_ROWS;
    localparam int COL_W   = (ROW_SIZE > 1) ? $clog2(ROW_SIZE) : 1;
    localparam int ROW_W   = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_PIX - 1);
    localparam logic [COL_W-1:0]  LAST_COL  = COL_W'(ROW_SIZE - 1);
    localparam logic [ROW_W-1:0]  LAST_ROW  = ROW_W'(NUM_ROWS - 1);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        DRAIN,
        FINISH
    } state_t;

    state_t state;

    logic [COL_W-1:0] rd_col;
    logic [ROW_W-1:0] rd_row;

    // Marker bits are packed as {sof, eol, eof} and ride along with each entry.
    logic [2:0]           issue_marks;
    logic                 ret_valid;
    logic [2:0]           ret_marks;
    logic                 skid_valid;
    logic [WORD_SIZE-1:0] skid_data;
    logic [2:0]           skid_marks;

    logic       hs;
    logic       out_free;
    logic [1:0] occ;

    assign hs       = pixel_valid & pixel_ready;
    assign out_free = ~pixel_valid | hs;

    // Pixels committed for the next cycle; a handshake this cycle frees its slot.
    assign occ = {1'b0, pixel_valid} + {1'b0, skid_valid} + {1'b0, ret_valid} - {1'b0, hs};

    assign mem_rd_en = (state == FETCH) && (occ < 2'd2);

    assign issue_marks = {
        (rd_row == '0) && (rd_col == '0),
        (rd_col == LAST_COL),
        (rd_row == LAST_ROW) && (rd_col == LAST_COL)
    };

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            mem_addr <= '0;
            rd_col   <= '0;
            rd_row   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        state    <= FETCH;
                        busy     <= 1'b1;
                        mem_addr <= '0;
                        rd_col   <= '0;
                        rd_row   <= '0;
                    end
                end
                FETCH: begin
                    if (mem_rd_en) begin
                        if (mem_addr == LAST_ADDR) begin
                            state <= DRAIN;
                        end else begin
                            mem_addr <= mem_addr + ADDR_W'(1);
                        end
                        if (rd_col == LAST_COL) begin
                            rd_col <= '0;
                            rd_row <= rd_row + ROW_W'(1);
                        end else begin
                            rd_col <= rd_col + COL_W'(1);
                        end
                    end
                end
                DRAIN: begin
                    if (hs && eof) begin
                        state <= FINISH;
                        done  <= 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    // The skid entry is always older than returning data, so it wins the output slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            ret_valid   <= 1'b0;
            ret_marks   <= '0;
            skid_valid  <= 1'b0;
            skid_data   <= '0;
            skid_marks  <= '0;
            pixel_valid <= 1'b0;
            pixel_out   <= '0;
            sof         <= 1'b0;
            eol         <= 1'b0;
            eof         <= 1'b0;
        end else begin
            ret_valid <= mem_rd_en;
            if (mem_rd_en) begin
                ret_marks <= issue_marks;
            end
            if (out_free) begin
                if (skid_valid) begin
                    pixel_valid     <= 1'b1;
                    pixel_out       <= skid_data;
                    {sof, eol, eof} <= skid_marks;
                    skid_valid      <= ret_valid;
                    if (ret_valid) begin
                        skid_data  <= mem_rd_data;
                        skid_marks <= ret_marks;
                    end
                end else if (ret_valid) begin
                    pixel_valid     <= 1'b1;
                    pixel_out       <= mem_rd_data;
                    {sof, eol, eof} <= ret_marks;
                end else begin
                    pixel_valid     <= 1'b0;
                    {sof, eol, eof} <= 3'b000;
                end
            end else if (ret_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= mem_rd_data;
                skid_marks <= ret_marks;
            end
        end
    end

endmodule

// File: tb/tb_conv_frame_streamer.sv
// Bench for conv_frame_streamer on a 4x3 frame: scenario table plus random
// ready/start traffic, checked against a raster-order scoreboard.
module tb_conv_frame_streamer;

    localparam int WORD_SIZE = 8;
    localparam int ROW_SIZE  = 4;
    localparam int NUM_ROWS  = 3;
    localparam int NUM_PIX   = ROW_SIZE * NUM_ROWS;
    localparam int ADDR_W    = $clog2(NUM_PIX);
    localparam int BUDGET    = 400;

    localparam int M_CONST   = 0;
    localparam int M_STALL   = 1;
    localparam int M_TOGGLE  = 2;
    localparam int M_INITLOW = 3;
    localparam int M_RANDOM  = 4;
    localparam int NUM_SCEN  = 14;

    typedef struct {
        int mode;
        int stall_pix;
        int stall_len;
        int restart_pix;
        int reset_pix;
        int start_on_done;
        int exp_pixels;
        int exp_dones;
        int exp_done_cyc;
    } scen_t;

    logic                 clk         = 1'b0;
    logic                 rst         = 1'b1;
    logic                 start       = 1'b0;
    logic                 pixel_ready = 1'b0;
    logic [WORD_SIZE-1:0] mem_rd_data = '0;
    logic                 busy;
    logic                 done;
    logic                 mem_rd_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [WORD_SIZE-1:0] pixel_out;
    logic                 pixel_valid;
    logic                 sof;
    logic                 eol;
    logic                 eof;

    logic [WORD_SIZE-1:0] frame [NUM_PIX];
    int assert_count = 0;
    int fail_count   = 0;
    scen_t scen [NUM_SCEN];

    conv_frame_streamer #(
        .WORD_SIZE(WORD_SIZE),
        .ROW_SIZE (ROW_SIZE),
        .NUM_ROWS (NUM_ROWS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .busy       (busy),
        .done       (done),
        .mem_rd_en  (mem_rd_en),
        .mem_addr   (mem_addr),
        .mem_rd_data(mem_rd_data),
        .pixel_out  (pixel_out),
        .pixel_valid(pixel_valid),
        .pixel_ready(pixel_ready),
        .sof        (sof),
        .eol        (eol),
        .eof        (eof)
    );

    always #5 clk = ~clk;

    // Synchronous-read frame memory: data appears one cycle after the strobe.
    always @(posedge clk) begin
        if (mem_rd_en) mem_rd_data <= frame[mem_addr];
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] required);
        assert_count++;
        if (actual !== required) begin
            fail_count++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, actual, required);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rdy, input logic rs);
        start       = st;
        pixel_ready = rdy;
        rst         = rs;
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, "_busy"}, 32'(busy), 0);
        checkOutput({tag, "_done"}, 32'(done), 0);
        checkOutput({tag, "_rd_en"}, 32'(mem_rd_en), 0);
        checkOutput({tag, "_addr"}, 32'(mem_addr), 0);
        checkOutput({tag, "_valid"}, 32'(pixel_valid), 0);
        checkOutput({tag, "_pixel"}, 32'(pixel_out), 0);
        checkOutput({tag, "_markers"}, 32'({sof, eol, eof}), 0);
    endtask

    task automatic runScenario(input scen_t s, input int id);
        int next_rd = 0;
        int next_idx = 0;
        int dones = 0;
        int done_cyc = -1;
        int last_hs = -100;
        int first_valid = -1;
        int reads = 0;
        int stall_cnt = 0;
        int rst_cyc = -1;
        bit restarted = 1'b0;
        bit prev_stall = 1'b0;
        bit exp_busy;
        logic [WORD_SIZE-1:0] prev_pix = '0;
        logic [2:0] prev_mk = '0;
        logic st, rdy, rs;

        for (int a = 0; a < NUM_PIX; a++) begin
            frame[a] = (s.mode == M_RANDOM) ? WORD_SIZE'($urandom) : WORD_SIZE'(a + 16);
        end
        $display("[TB] scenario %0d mode %0d", id, s.mode);

        for (int c = 0; c < BUDGET; c++) begin
            @(negedge clk);
            st  = (c == 0);
            rs  = 1'b0;
            rdy = 1'b1;
            case (s.mode)
                M_STALL: begin
                    if (pixel_valid && int'(pixel_out) == s.stall_pix && stall_cnt < s.stall_len) begin
                        rdy = 1'b0;
                        stall_cnt++;
                    end
                end
                M_TOGGLE:  rdy = (c % 2 == 0);
                M_INITLOW: rdy = (c >= 4);
                M_RANDOM: begin
                    rdy = ($urandom_range(0, 3) != 0);
                    if (c > 0 && done_cyc < 0 && $urandom_range(0, 7) == 0) st = 1'b1;
                end
                default: rdy = 1'b1;
            endcase
            if (s.restart_pix >= 0 && !restarted && pixel_valid && int'(pixel_out) == s.restart_pix) begin
                st = 1'b1;
                restarted = 1'b1;
            end
            if (s.start_on_done != 0 && done) st = 1'b1;
            if (s.reset_pix >= 0 && rst_cyc < 0 && pixel_valid && int'(pixel_out) == s.reset_pix) rs = 1'b1;
            applyStimulus(st, rdy, rs);
            #1;

            if (rst_cyc >= 0 && c == rst_cyc + 1) checkResetState("post_reset");

            if (rs) begin
                rst_cyc = c;
                prev_stall = 1'b0;
            end else begin
                if (prev_stall) begin
                    checkOutput("stall_valid_held", 32'(pixel_valid), 1);
                    checkOutput("stall_pixel_held", 32'(pixel_out), 32'(prev_pix));
                    checkOutput("stall_markers_held", 32'({sof, eol, eof}), 32'(prev_mk));
                end
                if (mem_rd_en) begin
                    checkOutput("rd_addr", 32'(mem_addr), 32'(next_rd));
                    next_rd++;
                    reads++;
                end
                if (s.mode == M_STALL && !rdy && stall_cnt >= 2) checkOutput("rd_en_while_skid_full", 32'(mem_rd_en), 0);
                if (s.mode == M_INITLOW && c == 3) checkOutput("reads_before_release", 32'(reads), 2);
                if (pixel_valid && first_valid < 0) begin
                    first_valid = c;
                    checkOutput("first_pixel_latency", 32'(c), 3);
                end
                if (pixel_valid && pixel_ready) begin
                    if (next_idx >= NUM_PIX) begin
                        checkOutput("pixel_overrun", 32'(next_idx), NUM_PIX - 1);
                    end else begin
                        checkOutput("pixel_value", 32'(pixel_out), 32'(frame[next_idx]));
                        checkOutput("sof", 32'(sof), 32'(next_idx == 0));
                        checkOutput("eol", 32'(eol), 32'(next_idx % ROW_SIZE == ROW_SIZE - 1));
                        checkOutput("eof", 32'(eof), 32'(next_idx == NUM_PIX - 1));
                    end
                    next_idx++;
                    last_hs = c;
                end
                if (done) begin
                    dones++;
                    done_cyc = c;
                    checkOutput("done_after_last_hs", 32'(c), 32'(last_hs + 1));
                end
                exp_busy = (c >= 1) && (rst_cyc < 0) && (dones == 0 || c == done_cyc);
                checkOutput("busy", 32'(busy), 32'(exp_busy));
                prev_stall = pixel_valid && !pixel_ready;
                prev_pix = pixel_out;
                prev_mk = {sof, eol, eof};
            end
            if (done_cyc >= 0 && c >= done_cyc + 4) break;
            if (rst_cyc >= 0 && c >= rst_cyc + 8) break;
        end

        checkOutput("pixel_count", 32'(next_idx), 32'(s.exp_pixels));
        checkOutput("done_count", 32'(dones), 32'(s.exp_dones));
        if (s.exp_done_cyc >= 0) checkOutput("done_cycle", 32'(done_cyc), 32'(s.exp_done_cyc));
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        // mode, stall_pix, stall_len, restart_pix, reset_pix, start_on_done, pixels, dones, done_cyc
        scen[0]  = '{M_CONST,   -1, 0, -1, -1, 0, 12, 1, 15};
        scen[1]  = '{M_STALL,   21, 5, -1, -1, 0, 12, 1, 20};
        scen[2]  = '{M_TOGGLE,  -1, 0, -1, -1, 0, 12, 1, 27};
        scen[3]  = '{M_CONST,   -1, 0, 18, -1, 0, 12, 1, 15};
        scen[4]  = '{M_CONST,   -1, 0, -1, 22, 0,  6, 0, -1};
        scen[5]  = '{M_CONST,   -1, 0, -1, -1, 0, 12, 1, 15};
        scen[6]  = '{M_INITLOW, -1, 0, -1, -1, 0, 12, 1, 16};
        scen[7]  = '{M_CONST,   -1, 0, -1, -1, 1, 12, 1, 15};
        for (int i = 8; i < NUM_SCEN; i++) begin
            scen[i] = '{M_RANDOM, -1, 0, -1, -1, 0, 12, 1, -1};
        end

        applyStimulus(1'b0, 1'b0, 1'b1);
        repeat (2) @(negedge clk);
        checkResetState("initial_reset");
        applyStimulus(1'b0, 1'b1, 1'b0);
        repeat (2) @(negedge clk);

        for (int i = 0; i < NUM_SCEN; i++) begin
            runScenario(scen[i], i);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
